vx_result_gather_unit: RTL and testbench

- Return-path counterpart of the execute-side packet splitter.
- Takes lane-sliced result packets from a functional unit: NUM_LANES wide, tagged with pid/sop/eop, sparse (all-zero-tmask packets skipped).
- Reassembles them into one SIMD_WIDTH-wide writeback packet per warp instruction.
- Sits between a functional unit's result output and the commit arbiter. One instance per block.

---
 rtl/vx_result_gather_unit.sv | 178 +++++++++++++++++
 tb/tb_vx_result_gather_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_result_gather_unit.sv
// ============================================================================
// Module   : vx_result_gather_unit
// Purpose  : Reassembles lane-sliced result packets into full-width writeback.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vx_result_gather_unit #(
  parameter int SIMD_WIDTH = 4,
  parameter int NUM_LANES  = 1,
  parameter int XLEN       = 32,
  parameter int NW_WIDTH   = 4,
  parameter int UUID_WIDTH = 44,
  parameter int PC_BITS    = 30,
  parameter int NR_BITS    = 5,
  localparam int NUM_PACKETS = SIMD_WIDTH / NUM_LANES,
  localparam int PID_W       = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [UUID_WIDTH-1:0]      in_uuid,
  input  logic [NW_WIDTH-1:0]        in_wid,
  input  logic [PC_BITS-1:0]         in_pc,
  input  logic                       in_wb,
  input  logic [NR_BITS-1:0]         in_rd,
  input  logic [NUM_LANES-1:0]       in_tmask,
  input  logic [NUM_LANES*XLEN-1:0]  in_data,
  input  logic [PID_W-1:0]           in_pid,
  input  logic                       in_sop,
  input  logic                       in_eop,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [UUID_WIDTH-1:0]      out_uuid,
  output logic [NW_WIDTH-1:0]        out_wid,
  output logic [PC_BITS-1:0]         out_pc,
  output logic                       out_wb,
  output logic [NR_BITS-1:0]         out_rd,
  output logic [SIMD_WIDTH-1:0]      out_tmask,
  output logic [SIMD_WIDTH*XLEN-1:0] out_data,
  output logic                       proto_err
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t                      r_state;
  logic [UUID_WIDTH-1:0]       r_acc_uuid;
  logic [NW_WIDTH-1:0]         r_acc_wid;
  logic [PC_BITS-1:0]          r_acc_pc;
  logic                        r_acc_wb;
  logic [NR_BITS-1:0]          r_acc_rd;
  logic [SIMD_WIDTH-1:0]       r_acc_tmask;
  logic [SIMD_WIDTH*XLEN-1:0]  r_acc_data;

  logic                        r_out_valid;
  logic [UUID_WIDTH-1:0]       r_out_uuid;
  logic [NW_WIDTH-1:0]         r_out_wid;
  logic [PC_BITS-1:0]          r_out_pc;
  logic                        r_out_wb;
  logic [NR_BITS-1:0]          r_out_rd;
  logic [SIMD_WIDTH-1:0]       r_out_tmask;
  logic [SIMD_WIDTH*XLEN-1:0]  r_out_data;
  logic                        r_proto_err;

  logic                        w_fire;
  logic                        w_accept;
  logic                        w_err;
  logic [UUID_WIDTH-1:0]       w_hdr_uuid;
  logic [NW_WIDTH-1:0]         w_hdr_wid;
  logic [PC_BITS-1:0]          w_hdr_pc;
  logic                        w_hdr_wb;
  logic [NR_BITS-1:0]          w_hdr_rd;
  logic [SIMD_WIDTH-1:0]       w_base_tmask;
  logic [SIMD_WIDTH*XLEN-1:0]  w_base_data;
  logic [SIMD_WIDTH-1:0]       w_mrg_tmask;
  logic [SIMD_WIDTH*XLEN-1:0]  w_mrg_data;

  // Only an eop needs the output register; partial packets never stall.
  assign in_ready = in_eop ? (!r_out_valid || out_ready) : 1'b1;
  assign w_fire   = in_valid && in_ready;
  assign w_accept = w_fire && (in_sop || (r_state == S_COLLECT));

  assign w_err = w_fire &&
                 ((in_sop && (r_state == S_COLLECT)) ||
                  (!in_sop && (r_state == S_IDLE)) ||
                  (!in_sop && (r_state == S_COLLECT) &&
                   ((in_uuid != r_acc_uuid) || (in_wid != r_acc_wid))));

  // An sop restarts from an empty accumulator, which also covers sop+eop.
  assign w_hdr_uuid   = in_sop ? in_uuid : r_acc_uuid;
  assign w_hdr_wid    = in_sop ? in_wid  : r_acc_wid;
  assign w_hdr_pc     = in_sop ? in_pc   : r_acc_pc;
  assign w_hdr_wb     = in_sop ? in_wb   : r_acc_wb;
  assign w_hdr_rd     = in_sop ? in_rd   : r_acc_rd;
  assign w_base_tmask = in_sop ? '0 : r_acc_tmask;
  assign w_base_data  = in_sop ? '0 : r_acc_data;

  always_comb begin
    w_mrg_tmask = w_base_tmask;
    w_mrg_data  = w_base_data;
    for (int p = 0; p < NUM_PACKETS; p++) begin
      if (in_pid == PID_W'(p)) begin
        w_mrg_tmask[p*NUM_LANES +: NUM_LANES] =
          w_base_tmask[p*NUM_LANES +: NUM_LANES] | in_tmask;
        w_mrg_data[p*NUM_LANES*XLEN +: NUM_LANES*XLEN] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_acc_uuid  <= '0;
      r_acc_wid   <= '0;
      r_acc_pc    <= '0;
      r_acc_wb    <= 1'b0;
      r_acc_rd    <= '0;
      r_acc_tmask <= '0;
      r_acc_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_uuid  <= '0;
      r_out_wid   <= '0;
      r_out_pc    <= '0;
      r_out_wb    <= 1'b0;
      r_out_rd    <= '0;
      r_out_tmask <= '0;
      r_out_data  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_proto_err <= w_err;
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (in_eop) begin
          r_out_valid <= 1'b1;
          r_out_uuid  <= w_hdr_uuid;
          r_out_wid   <= w_hdr_wid;
          r_out_pc    <= w_hdr_pc;
          r_out_wb    <= w_hdr_wb;
          r_out_rd    <= w_hdr_rd;
          r_out_tmask <= w_mrg_tmask;
          r_out_data  <= w_mrg_data;
          r_acc_tmask <= '0;
          r_acc_data  <= '0;
          r_state     <= S_IDLE;
        end else begin
          r_acc_uuid  <= w_hdr_uuid;
          r_acc_wid   <= w_hdr_wid;
          r_acc_pc    <= w_hdr_pc;
          r_acc_wb    <= w_hdr_wb;
          r_acc_rd    <= w_hdr_rd;
          r_acc_tmask <= w_mrg_tmask;
          r_acc_data  <= w_mrg_data;
          r_state     <= S_COLLECT;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_uuid  = r_out_uuid;
  assign out_wid   = r_out_wid;
  assign out_pc    = r_out_pc;
  assign out_wb    = r_out_wb;
  assign out_rd    = r_out_rd;
  assign out_tmask = r_out_tmask;
  assign out_data  = r_out_data;
  assign proto_err = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_vx_result_gather_unit.sv
// ============================================================================
// Module   : tb_vx_result_gather_unit
// Purpose  : Directed self-checking bench for vx_result_gather_unit.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vx_result_gather_unit;

  localparam logic [3:0]  WID = 4'h5;
  localparam logic [29:0] PC  = 30'h0000_1234;
  localparam logic [4:0]  RD  = 5'd9;

  logic         clk = 1'b0;
  logic         reset = 1'b0;

  logic         in_valid = 1'b0, in_ready;
  logic [43:0]  in_uuid = '0;
  logic [3:0]   in_wid = '0;
  logic [29:0]  in_pc = '0;
  logic         in_wb = 1'b0;
  logic [4:0]   in_rd = '0;
  logic [0:0]   in_tmask = '0;
  logic [31:0]  in_data = '0;
  logic [1:0]   in_pid = '0;
  logic         in_sop = 1'b0, in_eop = 1'b0;
  logic         out_valid, out_ready = 1'b1;
  logic [43:0]  out_uuid;
  logic [3:0]   out_wid;
  logic [29:0]  out_pc;
  logic         out_wb;
  logic [4:0]   out_rd;
  logic [3:0]   out_tmask;
  logic [127:0] out_data;
  logic         proto_err;

  logic         in_valid4 = 1'b0, in_ready4;
  logic [43:0]  in_uuid4 = '0;
  logic [3:0]   in_tmask4 = '0;
  logic [127:0] in_data4 = '0;
  logic [0:0]   in_pid4 = '0;
  logic         out_valid4, out_ready4 = 1'b1;
  logic [43:0]  out_uuid4;
  logic [3:0]   out_wid4;
  logic [29:0]  out_pc4;
  logic         out_wb4;
  logic [4:0]   out_rd4;
  logic [3:0]   out_tmask4;
  logic [127:0] out_data4;
  logic         proto_err4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vx_result_gather_unit u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_uuid(in_uuid), .in_wid(in_wid),
    .in_pc(in_pc), .in_wb(in_wb), .in_rd(in_rd), .in_tmask(in_tmask),
    .in_data(in_data), .in_pid(in_pid), .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_uuid(out_uuid),
    .out_wid(out_wid), .out_pc(out_pc), .out_wb(out_wb), .out_rd(out_rd),
    .out_tmask(out_tmask), .out_data(out_data), .proto_err(proto_err)
  );

  vx_result_gather_unit #(.NUM_LANES(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_uuid(in_uuid4), .in_wid(WID),
    .in_pc(PC), .in_wb(1'b1), .in_rd(RD), .in_tmask(in_tmask4),
    .in_data(in_data4), .in_pid(in_pid4), .in_sop(1'b1), .in_eop(1'b1),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_uuid(out_uuid4),
    .out_wid(out_wid4), .out_pc(out_pc4), .out_wb(out_wb4), .out_rd(out_rd4),
    .out_tmask(out_tmask4), .out_data(out_data4), .proto_err(proto_err4)
  );

  task automatic set_pkt(input logic [1:0] pid, input logic sop, input logic eop,
                         input logic [31:0] d, input logic [43:0] uuid);
    in_valid = 1'b1; in_pid = pid; in_sop = sop; in_eop = eop;
    in_tmask = 1'b1; in_data = d; in_uuid = uuid;
    in_wid = WID; in_pc = PC; in_wb = 1'b1; in_rd = RD;
  endtask

  // Drives one packet for exactly one edge; returns 1ns after that edge.
  task automatic pkt(input logic [1:0] pid, input logic sop, input logic eop,
                     input logic [31:0] d, input logic [43:0] uuid);
    set_pkt(pid, sop, eop, d, uuid);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic pkt4(input logic [3:0] tm, input logic [127:0] d, input logic [43:0] uuid);
    in_valid4 = 1'b1; in_tmask4 = tm; in_data4 = d; in_uuid4 = uuid;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", proto_err); end
    n_checks++; if (out_tmask !== 4'h0 || out_data !== 128'h0 || out_uuid !== 44'h0) begin
      n_fail++; $display("FAIL rst_fields: tmask %h data %h uuid %h want 0", out_tmask, out_data, out_uuid); end
    n_checks++; if (out_valid4 !== 1'b0 || out_data4 !== 128'h0) begin
      n_fail++; $display("FAIL rst_dut4: valid %b data %h want 0", out_valid4, out_data4); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_dense;
    out_ready = 1'b1;
    pkt(0, 1, 0, 32'hA0, 44'h0AB_CDEF_0123);
    pkt(1, 0, 0, 32'hA1, 44'h0AB_CDEF_0123);
    pkt(2, 0, 0, 32'hA2, 44'h0AB_CDEF_0123);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dense_early: got %b want 0", out_valid); end
    pkt(3, 0, 1, 32'hA3, 44'h0AB_CDEF_0123);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dense_valid: got %b want 1", out_valid); end
    n_checks++; if (out_tmask !== 4'b1111) begin n_fail++; $display("FAIL dense_tmask: got %b want 1111", out_tmask); end
    n_checks++; if (out_data !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
      n_fail++; $display("FAIL dense_data: got %h", out_data); end
    n_checks++; if (out_uuid !== 44'h0AB_CDEF_0123 || out_wid !== WID || out_pc !== PC ||
                    out_rd !== RD || out_wb !== 1'b1) begin
      n_fail++; $display("FAIL dense_hdr: uuid %h wid %h pc %h rd %0d wb %b", out_uuid, out_wid, out_pc, out_rd, out_wb); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dense_once: got %b want 0", out_valid); end
  endtask

  task automatic test_sparse;
    pkt(1, 1, 0, 32'h11, 44'h111);
    pkt(3, 0, 1, 32'h33, 44'h111);
    n_checks++; if (out_valid !== 1'b1 || out_tmask !== 4'b1010) begin
      n_fail++; $display("FAIL sparse_tmask: valid %b tmask %b want 1 1010", out_valid, out_tmask); end
    n_checks++; if (out_data !== {32'h33, 32'h0, 32'h11, 32'h0}) begin
      n_fail++; $display("FAIL sparse_data: got %h", out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    pkt(0, 1, 0, 32'hB0, 44'hC0C);
    pkt(1, 0, 0, 32'hB1, 44'hC0C);
    pkt(2, 0, 0, 32'hB2, 44'hC0C);
    pkt(3, 0, 1, 32'hB3, 44'hC0C);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first: got %b want 1", out_valid); end
    pkt(0, 1, 0, 32'hC0, 44'hD0D);
    pkt(1, 0, 0, 32'hC1, 44'hD0D);
    pkt(2, 0, 0, 32'hC2, 44'hD0D);
    set_pkt(3, 0, 1, 32'hC3, 44'hD0D);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall: in_ready %b want 0", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b0 || out_uuid !== 44'hC0C ||
                    out_data !== {32'hB3, 32'hB2, 32'hB1, 32'hB0}) begin
      n_fail++; $display("FAIL bp_hold: in_ready %b uuid %h data %h", in_ready, out_uuid, out_data); end
    out_ready = 1'b1; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: in_ready %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_eop = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_uuid !== 44'hD0D ||
                    out_data !== {32'hC3, 32'hC2, 32'hC1, 32'hC0}) begin
      n_fail++; $display("FAIL bp_second: valid %b uuid %h data %h", out_valid, out_uuid, out_data); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_single_packet;
    logic [127:0] d [3];
    logic [3:0]   tm [3];
    d[0] = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677; tm[0] = 4'b1111;
    d[1] = 128'hDEAD_BEEF_0000_0000_CAFE_F00D_0000_0000; tm[1] = 4'b0101;
    d[2] = 128'h8000_0001_0000_0000_0000_0000_0000_0000; tm[2] = 4'b1000;
    out_ready4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pkt4(tm[k], d[k], 44'h400 + 44'(k));
      n_checks++; if (out_valid4 !== 1'b1 || out_tmask4 !== tm[k] || out_data4 !== d[k] ||
                      out_uuid4 !== 44'h400 + 44'(k) || proto_err4 !== 1'b0) begin
        n_fail++; $display("FAIL single_%0d: valid %b tmask %b data %h uuid %h err %b",
                           k, out_valid4, out_tmask4, out_data4, out_uuid4, proto_err4); end
    end
    @(posedge clk); #1;
    n_checks++; if (out_valid4 !== 1'b0 || proto_err4 !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: valid %b err %b want 0 0", out_valid4, proto_err4); end
  endtask

  task automatic test_errors;
    out_ready = 1'b1;
    pkt(0, 1, 0, 32'hE1, 44'hE01);
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL err_none: got %b want 0", proto_err); end
    pkt(0, 1, 0, 32'hE2, 44'hE02);
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL err_sop: got %b want 1", proto_err); end
    pkt(3, 0, 1, 32'hE3, 44'hE02);
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %b want 0", proto_err); end
    n_checks++; if (out_valid !== 1'b1 || out_uuid !== 44'hE02 || out_tmask !== 4'b1001 ||
                    out_data !== {32'hE3, 32'h0, 32'h0, 32'hE2}) begin
      n_fail++; $display("FAIL err_restart: valid %b uuid %h tmask %b data %h", out_valid, out_uuid, out_tmask, out_data); end
    @(posedge clk); #1;
    pkt(2, 0, 0, 32'h77, 44'hF0F);
    n_checks++; if (proto_err !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL err_lone: err %b valid %b want 1 0", proto_err, out_valid); end
    @(posedge clk); #1;
    n_checks++; if (proto_err !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL err_lone_after: err %b valid %b want 0 0", proto_err, out_valid); end
    pkt(0, 1, 0, 32'h50, 44'h606);
    pkt(1, 0, 0, 32'h51, 44'h707);
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL err_hdr: got %b want 1", proto_err); end
    pkt(3, 0, 1, 32'h53, 44'h606);
    n_checks++; if (out_valid !== 1'b1 || out_uuid !== 44'h606 || out_tmask !== 4'b1011 ||
                    out_data !== {32'h53, 32'h0, 32'h51, 32'h50}) begin
      n_fail++; $display("FAIL err_hdr_merge: valid %b uuid %h tmask %b data %h", out_valid, out_uuid, out_tmask, out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) pkt(2'(k), k == 0, k == 3, 32'h60 + 32'(k), 44'h900);
    pkt(0, 1, 0, 32'h70, 44'h901);
    pkt(1, 0, 0, 32'h71, 44'h901);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got %b want 1", out_valid); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_tmask !== 4'h0 || out_data !== 128'h0) begin
      n_fail++; $display("FAIL rmid_async: valid %b tmask %b data %h", out_valid, out_tmask, out_data); end
    @(negedge clk); reset = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    pkt(2, 0, 1, 32'h99, 44'h901);
    n_checks++; if (proto_err !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_idle: err %b valid %b want 1 0", proto_err, out_valid); end
    for (int k = 0; k < 4; k++) pkt(2'(k), k == 0, k == 3, 32'h80 + 32'(k), 44'h902);
    n_checks++; if (out_valid !== 1'b1 || out_uuid !== 44'h902 || out_tmask !== 4'b1111 ||
                    out_data !== {32'h83, 32'h82, 32'h81, 32'h80}) begin
      n_fail++; $display("FAIL rmid_fresh: valid %b uuid %h tmask %b data %h", out_valid, out_uuid, out_tmask, out_data); end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_dense();
    test_sparse();
    test_back_to_back();
    test_single_packet();
    test_errors();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
